bp_cfg_sequencer: RTL and testbench
===================================

BP_CFG_SEQUENCER -- requirements
Module: bp_cfg_sequencer

Interface
REQ-001 SHALL have parameter num_core_p, default 2, number of cores to configure (1..16).
REQ-002 SHALL have parameter cfg_addr_width_p, default 4, config register address width.
REQ-003 SHALL have parameter cfg_data_width_p, default 16, config write data width.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  pulse that begins a configuration run.
REQ-007 SHALL have port cfg_v_o  output  1  config write valid.
REQ-008 SHALL have port cfg_ready_i  input  1  target accepts write when high with cfg_v_o.
REQ-009 SHALL have port cfg_core_o  output  safe_clog2(num_core_p)  target core index.
REQ-010 SHALL have port cfg_addr_o  output  cfg_addr_width_p  config register address.
REQ-011 SHALL have port cfg_data_o  output  cfg_data_width_p  config write data.
REQ-012 SHALL have port busy_o  output  1  high while a run is in progress.
REQ-013 SHALL have port done_o  output  1  high from run completion until next start or reset.

Function
REQ-014 SHALL implement FSM states IDLE, CONFIG, UNFREEZE, DONE.
REQ-015 IDLE/DONE SHALL move to CONFIG on start_i=1, clearing core counter and step counter to 0; start_i SHALL be ignored in CONFIG and UNFREEZE.
REQ-016 In CONFIG, per core c (ascending from 0), four writes SHALL issue in order: step0 addr 0 data 1 (freeze); step1 addr 1 data c (core id); step2 addr 2 data 2c (lce id 0); step3 addr 3 data 2c+1 (lce id 1).
REQ-017 Data values SHALL be zero-extended to cfg_data_width_p; addresses zero-extended to cfg_addr_width_p.
REQ-018 A write SHALL complete only on the cycle cfg_v_o=1 and cfg_ready_i=1; step counter SHALL then advance; after step3 it SHALL wrap to 0 and core counter increment.
REQ-019 After step3 of core num_core_p-1 completes, FSM SHALL enter UNFREEZE with core counter 0.
REQ-020 In UNFREEZE, one write per core SHALL issue in ascending order: addr 0 data 0; after core num_core_p-1 completes, FSM SHALL enter DONE.
REQ-021 cfg_v_o SHALL be 1 in CONFIG and UNFREEZE, 0 in IDLE and DONE; cfg_v_o SHALL not drop and cfg_core_o/addr/data SHALL remain stable while cfg_ready_i=0.
REQ-022 Outputs SHALL be driven from registered state only; no combinational path from cfg_ready_i to cfg_v_o/addr/data/core.
REQ-023 Back-to-back accepts SHALL sustain one write per cycle; total run with ready tied high SHALL take exactly 5*num_core_p accepting cycles.
REQ-024 busy_o SHALL equal 1 in CONFIG/UNFREEZE, else 0; done_o SHALL equal 1 only in DONE.
REQ-025 start_i in DONE SHALL clear done_o on the next cycle and restart a full run.
REQ-026 With num_core_p=1, cfg_core_o SHALL be 1 bit, constantly 0.
REQ-027 cfg_core_o, cfg_addr_o, cfg_data_o SHALL be 0 in IDLE.

Reset
REQ-028 reset_i=1 SHALL, on the next clock edge, force IDLE, counters 0, cfg_v_o=0, busy_o=0, done_o=0, all payload outputs 0.
REQ-029 reset_i asserted mid-run (including cycle of a handshake) SHALL abort the run with no further writes; the pending handshake is discarded.
REQ-030 start_i coincident with reset_i SHALL be ignored.

Verification
REQ-031 num_core_p=2, ready tied 1, start pulse -> 10 consecutive writes: (0,0,1)(0,1,0)(0,2,0)(0,3,1)(1,0,1)(1,1,1)(1,2,2)(1,3,3)(0,0,0)(1,0,0) as (core,addr,data); done_o=1 the cycle after last.
REQ-032 Random ready backpressure (50%) -> identical write sequence; payload stable every stalled cycle; exactly 10 accepts.
REQ-033 reset_i pulsed after 3rd accept -> cfg_v_o=0 next cycle; later start yields full sequence from (0,0,1).
REQ-034 start_i pulsed during CONFIG -> ignored; sequence and count unchanged.
REQ-035 start_i in DONE -> done_o falls next cycle, second identical 10-write run.
REQ-036 num_core_p=1 -> writes (0,0,1)(0,1,0)(0,2,0)(0,3,1)(0,0,0), then done_o=1.

Source files
------------

// File: rtl/bp_cfg_sequencer_if.sv
// Config-write bus between bp_cfg_sequencer (master) and the cores being configured (slave).
// One write transfers when cfg_v and cfg_ready are both high on a rising clock edge.
interface bp_cfg_sequencer_if #(
    parameter int num_core_p       = 2,
    parameter int cfg_addr_width_p = 4,
    parameter int cfg_data_width_p = 16,
    localparam int core_width_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1
) ();

    logic                        cfg_v;
    logic                        cfg_ready;
    logic [core_width_lp-1:0]    cfg_core;
    logic [cfg_addr_width_p-1:0] cfg_addr;
    logic [cfg_data_width_p-1:0] cfg_data;

    modport master (
        output cfg_v,
        output cfg_core,
        output cfg_addr,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_v,
        input  cfg_core,
        input  cfg_addr,
        input  cfg_data,
        output cfg_ready
    );

endinterface

// File: rtl/bp_cfg_sequencer.sv
// Boot-time configuration sequencer: for every core it issues freeze, core id and
// two LCE ids, then sweeps all cores again to unfreeze them. Every output is a decode
// of registered state, so cfg_ready_i never reaches an output combinationally.
module bp_cfg_sequencer #(
    parameter int num_core_p       = 2,
    parameter int cfg_addr_width_p = 4,
    parameter int cfg_data_width_p = 16,
    localparam int core_width_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_width_lp-1:0]    cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    output logic                        busy_o,
    output logic                        done_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIG   = 2'd1,
        UNFREEZE = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [core_width_lp-1:0] last_core_lp = core_width_lp'(num_core_p - 1);

    state_e                   state_q, state_d;
    logic [core_width_lp-1:0] core_q, core_d;
    logic [1:0]               step_q, step_d;

    logic                     accept;
    logic [31:0]              core_ext;
    logic [31:0]              step_data;

    assign accept   = cfg_v_o & cfg_ready_i;
    assign core_ext = 32'(core_q);

    // State register: synchronous reset wins over everything, including a pending handshake.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments here so every flop samples the pre-edge values
        // of the others; blocking would create order-dependent simulation races.
        if (reset_i) begin
            state_q <= IDLE;
            core_q  <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic: counters advance only on an accepted write.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable; a missed branch
        // would otherwise infer a latch.
        state_d = state_q;
        core_d  = core_q;
        step_d  = step_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = CONFIG;
                    core_d  = '0;
                    step_d  = '0;
                end
            end
            CONFIG: begin
                if (accept) begin
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        if (core_q == last_core_lp) begin
                            state_d = UNFREEZE;
                            core_d  = '0;
                        end else begin
                            core_d = core_q + core_width_lp'(1);
                        end
                    end
                end
            end
            UNFREEZE: begin
                if (accept) begin
                    if (core_q == last_core_lp) begin
                        state_d = DONE;
                        core_d  = '0;
                    end else begin
                        core_d = core_q + core_width_lp'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write payload for the current CONFIG step: freeze, core id, lce id 0, lce id 1.
    always_comb begin
        step_data = 32'd0;
        unique case (step_q)
            2'd0: step_data = 32'd1;
            2'd1: step_data = core_ext;
            2'd2: step_data = core_ext << 1;
            2'd3: step_data = (core_ext << 1) | 32'd1;
            default: step_data = 32'd0;
        endcase
    end

    // Output decode: payload is held constant by the registers while a write stalls.
    always_comb begin
        cfg_v_o    = 1'b0;
        cfg_core_o = '0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            CONFIG: begin
                cfg_v_o    = 1'b1;
                busy_o     = 1'b1;
                cfg_core_o = core_q;
                cfg_addr_o = cfg_addr_width_p'(step_q);
                cfg_data_o = cfg_data_width_p'(step_data);
            end
            UNFREEZE: begin
                cfg_v_o    = 1'b1;
                busy_o     = 1'b1;
                cfg_core_o = core_q;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Directed bench for bp_cfg_sequencer: a two-core instance for the main scenarios and a
// one-core instance for the degenerate width case.
module tb_bp_cfg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i;
    logic start_a, busy_a, done_a;
    logic start_b, busy_b, done_b;

    bp_cfg_sequencer_if #(.num_core_p(2)) cfg_a ();
    bp_cfg_sequencer_if #(.num_core_p(1)) cfg_b ();

    bp_cfg_sequencer #(.num_core_p(2)) dut_a (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_a),
        .cfg_v_o     (cfg_a.cfg_v),
        .cfg_ready_i (cfg_a.cfg_ready),
        .cfg_core_o  (cfg_a.cfg_core),
        .cfg_addr_o  (cfg_a.cfg_addr),
        .cfg_data_o  (cfg_a.cfg_data),
        .busy_o      (busy_a),
        .done_o      (done_a)
    );

    bp_cfg_sequencer #(.num_core_p(1)) dut_b (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_b),
        .cfg_v_o     (cfg_b.cfg_v),
        .cfg_ready_i (cfg_b.cfg_ready),
        .cfg_core_o  (cfg_b.cfg_core),
        .cfg_addr_o  (cfg_b.cfg_addr),
        .cfg_data_o  (cfg_b.cfg_data),
        .busy_o      (busy_b),
        .done_o      (done_b)
    );

    // Hand-computed write sequences as (core, addr, data).
    int exp_core_a [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1};
    int exp_addr_a [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
    int exp_data_a [10] = '{1, 0, 0, 1, 1, 1, 2, 3, 0, 0};
    int exp_addr_b [5]  = '{0, 1, 2, 3, 0};
    int exp_data_b [5]  = '{1, 0, 0, 1, 0};

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_v"},    cfg_a.cfg_v,    0);
        check({tag, "_busy"}, busy_a,         0);
        check({tag, "_done"}, done_a,         0);
        check({tag, "_core"}, cfg_a.cfg_core, 0);
        check({tag, "_addr"}, cfg_a.cfg_addr, 0);
        check({tag, "_data"}, cfg_a.cfg_data, 0);
    endtask

    // Full run on the two-core instance, optionally with random backpressure and
    // with start_i poked during CONFIG and UNFREEZE.
    task automatic run_a(input bit bp, input bit poke_start);
        int acc = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [31:0] pc = '0, pa = '0, pd = '0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("run_busy", busy_a, 1);
        check("run_done_clear", done_a, 0);
        while (acc < 10 && cyc < 200) begin
            check("v_high", cfg_a.cfg_v, 1);
            if (stalled) begin
                check("stall_core", cfg_a.cfg_core, pc);
                check("stall_addr", cfg_a.cfg_addr, pa);
                check("stall_data", cfg_a.cfg_data, pd);
            end
            cfg_a.cfg_ready = bp ? 1'($urandom_range(1)) : 1'b1;
            start_a = poke_start && (acc == 2 || acc == 5 || acc == 8);
            if (cfg_a.cfg_v && cfg_a.cfg_ready) begin
                check("w_core", cfg_a.cfg_core, exp_core_a[acc]);
                check("w_addr", cfg_a.cfg_addr, exp_addr_a[acc]);
                check("w_data", cfg_a.cfg_data, exp_data_a[acc]);
                acc++;
            end
            stalled = cfg_a.cfg_v && !cfg_a.cfg_ready;
            pc = cfg_a.cfg_core;
            pa = cfg_a.cfg_addr;
            pd = cfg_a.cfg_data;
            tick();
            cyc++;
        end
        cfg_a.cfg_ready = 1'b0;
        start_a = 1'b0;
        check("accepts", acc, 10);
        if (!bp) check("cycles", cyc, 10);
        check("end_done", done_a, 1);
        check("end_v", cfg_a.cfg_v, 0);
        check("end_busy", busy_a, 0);
    endtask

    initial begin
        int acc_b;
        int cyc_b;
        reset_i = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        cfg_a.cfg_ready = 1'b0;
        cfg_b.cfg_ready = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        check_idle_a("rst");
        check("rst_b_v", cfg_b.cfg_v, 0);
        check("rst_b_done", done_b, 0);

        // Ready tied high: ten back-to-back writes, then DONE holds.
        run_a(1'b0, 1'b0);
        tick();
        check("done_hold", done_a, 1);

        // Restart from DONE with backpressure and ignored start pulses.
        run_a(1'b1, 1'b1);
        run_a(1'b1, 1'b0);

        // Abort after the third accept; reset lands on a handshake cycle.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cfg_a.cfg_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("ab_addr", cfg_a.cfg_addr, exp_addr_a[i]);
            check("ab_data", cfg_a.cfg_data, exp_data_a[i]);
            tick();
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_idle_a("abort");
        for (int i = 0; i < 3; i++) begin
            check("abort_quiet", cfg_a.cfg_v, 0);
            tick();
        end
        cfg_a.cfg_ready = 1'b0;

        // start_i coincident with reset_i is ignored.
        reset_i = 1'b1;
        start_a = 1'b1;
        tick();
        reset_i = 1'b0;
        start_a = 1'b0;
        check_idle_a("rst_start");
        tick();
        check("rst_start_v2", cfg_a.cfg_v, 0);

        // Fresh run after the abort starts again from (0,0,1).
        run_a(1'b0, 1'b0);

        // Single-core instance: five writes, core index always 0.
        acc_b = 0;
        cyc_b = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cfg_b.cfg_ready = 1'b1;
        while (acc_b < 5 && cyc_b < 50) begin
            check("b_v", cfg_b.cfg_v, 1);
            check("b_busy", busy_b, 1);
            if (cfg_b.cfg_v) begin
                check("b_core", cfg_b.cfg_core, 0);
                check("b_addr", cfg_b.cfg_addr, exp_addr_b[acc_b]);
                check("b_data", cfg_b.cfg_data, exp_data_b[acc_b]);
                acc_b++;
            end
            tick();
            cyc_b++;
        end
        cfg_b.cfg_ready = 1'b0;
        check("b_accepts", acc_b, 5);
        check("b_done", done_b, 1);
        check("b_end_v", cfg_b.cfg_v, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
